// File: rtl/sc_ulpi_rx_if.sv
// ULPI receive-side bundle: PHY-driven dir/nxt/data, the register-read
// request from the TX side, and every decoded output of the receive path.
interface sc_ulpi_rx_if;
  logic       ULPI_DIR;
  logic       ULPI_NXT;
  logic [7:0] ULPI_DIN;
  logic       REG_RD_REQ;
  logic [7:0] RXCMD;
  logic       RXCMD_VLD;
  logic       RX_ACTIVE;
  logic [7:0] RX_DATA;
  logic       RX_DVLD;
  logic       RX_EOP;
  logic       RX_ERR;
  logic [7:0] REG_RDATA;
  logic       REG_RVLD;
  logic       REG_RD_TMO;
  logic       BUS_OWN;

  // Stimulus / upstream side: drives the sampled bus and the read request.
  modport master (
    output ULPI_DIR, ULPI_NXT, ULPI_DIN, REG_RD_REQ,
    input  RXCMD, RXCMD_VLD, RX_ACTIVE, RX_DATA, RX_DVLD, RX_EOP, RX_ERR,
           REG_RDATA, REG_RVLD, REG_RD_TMO, BUS_OWN
  );

  // Receive path itself.
  modport slave (
    input  ULPI_DIR, ULPI_NXT, ULPI_DIN, REG_RD_REQ,
    output RXCMD, RXCMD_VLD, RX_ACTIVE, RX_DATA, RX_DVLD, RX_EOP, RX_ERR,
           REG_RDATA, REG_RVLD, REG_RD_TMO, BUS_OWN
  );
endinterface

// File: rtl/sc_ulpi_rx.sv
// Link-side ULPI receive path: tracks bus turnaround, decodes RX CMD bytes,
// streams USB packet bytes with EOP/error flags, and captures register-read
// data returned by the PHY (with a read timeout). All outputs are registered.
module sc_ulpi_rx #(
  parameter int RD_TMO_CYC = 16
) (
  input logic         CLK,
  input logic         RST,
  sc_ulpi_rx_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TURN_IN  = 2'd1,
    RECV     = 2'd2,
    TURN_OUT = 2'd3
  } state_t;

  // RxEvent encoding in RX CMD bits [5:4]
  localparam logic [1:0] EV_NONE    = 2'b00;
  localparam logic [1:0] EV_ACTIVE  = 2'b01;
  localparam logic [1:0] EV_DISCON  = 2'b10;
  localparam logic [1:0] EV_ERROR   = 2'b11;

  localparam logic [7:0] TMO_LOAD = 8'(RD_TMO_CYC);

  state_t     state;
  state_t     stateNext;
  logic       turnNxt;
  logic       firstByte;
  logic       errFlag;
  logic       rdPend;
  logic [7:0] tmoCnt;

  logic [7:0] rxCmdQ;
  logic       rxCmdVldQ;
  logic       rxActiveQ;
  logic [7:0] rxDataQ;
  logic       rxDvldQ;
  logic       rxEopQ;
  logic       rxErrQ;
  logic [7:0] regRdataQ;
  logic       regRvldQ;
  logic       regTmoQ;
  logic       busOwnQ;

  logic       dir;
  logic       nxt;
  logic [7:0] din;
  logic [1:0] rxEvent;
  logic       linkTurn;

  assign dir      = bus.ULPI_DIR;
  assign nxt      = bus.ULPI_NXT;
  assign din      = bus.ULPI_DIN;
  assign rxEvent  = din[5:4];
  // States in which the link side owns (or is about to own) the bus; the
  // read timeout only runs here and a dir rise here is a fresh turnaround.
  assign linkTurn = (state == IDLE) || (state == TURN_OUT);

  // Next-state decode for turnaround tracking; BUS_OWN is registered from it.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:     if (dir) stateNext = TURN_IN;
      TURN_IN:  stateNext = dir ? RECV : TURN_OUT;
      RECV:     if (!dir) stateNext = TURN_OUT;
      TURN_OUT: stateNext = dir ? TURN_IN : IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  // Receive FSM with registered decode outputs and register-read tracking.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      turnNxt   <= 1'b0;
      firstByte <= 1'b0;
      errFlag   <= 1'b0;
      rdPend    <= 1'b0;
      tmoCnt    <= 8'd0;
      rxCmdQ    <= 8'h00;
      rxCmdVldQ <= 1'b0;
      rxActiveQ <= 1'b0;
      rxDataQ   <= 8'h00;
      rxDvldQ   <= 1'b0;
      rxEopQ    <= 1'b0;
      rxErrQ    <= 1'b0;
      regRdataQ <= 8'h00;
      regRvldQ  <= 1'b0;
      regTmoQ   <= 1'b0;
      busOwnQ   <= 1'b1;
    end else begin
      state     <= stateNext;
      busOwnQ   <= (stateNext == IDLE) && !dir;
      rxCmdVldQ <= 1'b0;
      rxDvldQ   <= 1'b0;
      rxEopQ    <= 1'b0;
      rxErrQ    <= 1'b0;
      regRvldQ  <= 1'b0;
      regTmoQ   <= 1'b0;

      case (state)
        IDLE, TURN_OUT: begin
          // Turnaround cycle: data is not valid, only nxt matters.
          if (dir) turnNxt <= nxt;
        end
        TURN_IN: begin
          firstByte <= dir;
          if (dir && turnNxt) rxActiveQ <= 1'b1;
        end
        RECV: begin
          firstByte <= 1'b0;
          if (dir) begin
            if (rdPend && firstByte) begin
              // First byte after a RegRead turnaround is the register value.
              regRdataQ <= din;
              regRvldQ  <= 1'b1;
              rdPend    <= 1'b0;
              tmoCnt    <= 8'd0;
            end else if (nxt) begin
              if (rxActiveQ) begin
                rxDataQ <= din;
                rxDvldQ <= 1'b1;
              end
            end else begin
              rxCmdQ    <= din;
              rxCmdVldQ <= 1'b1;
              if (rxEvent == EV_ACTIVE || rxEvent == EV_ERROR) begin
                rxActiveQ <= 1'b1;
                if (rxEvent == EV_ERROR) errFlag <= 1'b1;
              end else if ((rxEvent == EV_NONE || rxEvent == EV_DISCON) && rxActiveQ) begin
                rxEopQ    <= 1'b1;
                rxErrQ    <= errFlag;
                rxActiveQ <= 1'b0;
                errFlag   <= 1'b0;
              end
            end
          end else if (rxActiveQ) begin
            // PHY released the bus mid-packet: report an aborted packet.
            rxEopQ    <= 1'b1;
            rxErrQ    <= 1'b1;
            rxActiveQ <= 1'b0;
            errFlag   <= 1'b0;
          end
        end
        default: ;
      endcase

      if (rdPend && linkTurn) begin
        if (tmoCnt <= 8'd1) begin
          regTmoQ <= 1'b1;
          rdPend  <= 1'b0;
          tmoCnt  <= 8'd0;
        end else begin
          tmoCnt <= tmoCnt - 8'd1;
        end
      end

      // A receive turnaround pre-empts an outstanding read.
      if (rdPend && linkTurn && dir && nxt) begin
        regTmoQ <= 1'b1;
        rdPend  <= 1'b0;
        tmoCnt  <= 8'd0;
      end

      // Only one read outstanding; a repeat request restarts the window.
      if (bus.REG_RD_REQ) begin
        rdPend <= 1'b1;
        tmoCnt <= TMO_LOAD;
      end
    end
  end

  assign bus.RXCMD      = rxCmdQ;
  assign bus.RXCMD_VLD  = rxCmdVldQ;
  assign bus.RX_ACTIVE  = rxActiveQ;
  assign bus.RX_DATA    = rxDataQ;
  assign bus.RX_DVLD    = rxDvldQ;
  assign bus.RX_EOP     = rxEopQ;
  assign bus.RX_ERR     = rxErrQ;
  assign bus.REG_RDATA  = regRdataQ;
  assign bus.REG_RVLD   = regRvldQ;
  assign bus.REG_RD_TMO = regTmoQ;
  assign bus.BUS_OWN    = busOwnQ;

endmodule

// File: doc/sc_ulpi_rx.md
Name: sc_ulpi_rx

Overview:
- Link-side ULPI receive path. Samples the PHY-driven half of the bus (dir/nxt/data).
- Performs bus turnaround tracking and decodes RX CMD bytes into the rxCmd_s fields from sc_ulpi_pkg.
- Streams received USB packet bytes, with end-of-packet and error flags.
- Captures register-read data returned by the PHY, including a read timeout.
- Counterpart to the TX CMD / register-write transmitter; sits between the ULPI I/O registers and the SCBC packet engine.

Parameters:
RD_TMO_CYC, 16, cycles allowed from REG_RD_REQ to read-data turnaround before REG_RD_TMO fires (range 2..255)

Ports:
CLK  in  1  ULPI 60 MHz clock
RST  in  1  asynchronous active-high reset
ULPI_DIR  in  1  dir, already registered at IOB
ULPI_NXT  in  1  nxt, already registered at IOB
ULPI_DIN  in  8  data bus input, already registered at IOB
REG_RD_REQ  in  1  pulse from the TX side: PHY accepted the RegRead TX CMD (nxt seen on its command byte)
RXCMD  out  8  last RX CMD, rxCmd_s layout
RXCMD_VLD  out  1  1-cycle strobe when RXCMD is updated
RX_ACTIVE  out  1  USB receive packet in progress
RX_DATA  out  8  received USB byte
RX_DVLD  out  1  RX_DATA valid strobe
RX_EOP  out  1  1-cycle end-of-packet strobe
RX_ERR  out  1  qualifies RX_EOP: rxError seen during the packet, or packet aborted by dir fall
REG_RDATA  out  8  register read data
REG_RVLD  out  1  REG_RDATA valid strobe
REG_RD_TMO  out  1  1-cycle read timeout strobe
BUS_OWN  out  1  1 = link may drive data (state IDLE and ULPI_DIR=0)

Behaviour:
- Reset values: all outputs 0, except BUS_OWN=1. RXCMD=8'h00. State IDLE. Read-pending flag 0. Timeout counter 0.
- All outputs are registered, with 1 cycle latency from the sampled inputs.
- FSM states:
  - IDLE, TURN_IN, RECV, TURN_OUT.
- IDLE:
  - ULPI_DIR=1 -> TURN_IN.
  - In the same cycle, capture ULPI_NXT as turn_nxt.
  - ULPI_DIN is ignored in the turnaround cycle.
- TURN_IN, one cycle, then RECV.
  - If turn_nxt=1: set RX_ACTIVE=1 (packet start signalled at turnaround).
  - If ULPI_DIR=0 in TURN_IN: go to TURN_OUT, no data.
- RECV while ULPI_DIR=1:
  - Read-pending=1 and this is the first RECV byte: the byte is register data.
    - Output REG_RDATA and REG_RVLD; clear read-pending and the timeout counter.
    - nxt is ignored on this cycle.
  - Otherwise, ULPI_NXT=1: USB data byte -> RX_DATA/RX_DVLD. A data byte while RX_ACTIVE=0 is dropped, no strobe.
  - Otherwise, ULPI_NXT=0: RX CMD -> RXCMD/RXCMD_VLD.
    - rxEvent bits [5:4] = rxActive or rxError: RX_ACTIVE=1. rxError also sets the sticky err flag.
    - rxEvent = noEvent or hostDiscon while RX_ACTIVE=1: RX_EOP=1 with RX_ERR=err flag. Then RX_ACTIVE=0 and the err flag clears.
- RECV with ULPI_DIR=0 -> TURN_OUT.
  - If RX_ACTIVE=1: RX_EOP=1, RX_ERR=1 (abort), RX_ACTIVE=0.
- TURN_OUT: one cycle, data ignored, then IDLE.
  - If ULPI_DIR=1 in TURN_OUT: go directly to TURN_IN, capturing nxt.
- BUS_OWN = (state==IDLE) and not ULPI_DIR. It is registered from the next-state logic, so it deasserts in the same cycle dir rises is observed.
- Register read:
  - REG_RD_REQ sets read-pending and loads the counter with RD_TMO_CYC.
  - The counter decrements each cycle while state is IDLE or TURN_OUT.
  - At 0 with read-pending still set: REG_RD_TMO=1 and read-pending clears.
  - If dir rises with turn_nxt=1 while read-pending is set: the read was aborted by PHY receive.
    - Read-pending clears, REG_RD_TMO=1, and the normal packet-start path is taken.
  - REG_RD_REQ while read-pending is already set: reload the counter. Only one read is outstanding.
- Simultaneous events:
  - RX_EOP and RX_DVLD never coincide.
  - RX_EOP and RXCMD_VLD coincide on an end-by-RXCMD.
- Async RST mid-packet: all state clears immediately. No EOP is emitted.

Test Plan:
- RX CMD only: dir 0->1 with nxt=0, then DIN=8'h4E with nxt=0, then dir 0.
  - Expect RXCMD=8'h4E and RXCMD_VLD for 1 cycle.
  - Expect lineState=2'b10, RX_ACTIVE=0, BUS_OWN=1 two cycles after dir fall.
- Packet via turnaround: dir and nxt rise together, then 3 bytes A5,5A,C3 with nxt=1, then RX CMD 8'h00.
  - Expect RX_ACTIVE=1 and three RX_DVLD strobes in order.
  - Expect RX_EOP=1 with RX_ERR=0, coincident with RXCMD_VLD.
- Error packet: RX CMD 8'h10 (rxActive), data 11,22, RX CMD 8'h30 (rxError), then 8'h00.
  - Expect 2 data strobes, then RX_EOP=1 with RX_ERR=1.
- Register read: REG_RD_REQ pulse, dir rises 3 cycles later, byte 8'h24, dir falls.
  - Expect REG_RDATA=8'h24 and REG_RVLD=1.
  - Expect no RXCMD_VLD and no REG_RD_TMO.
- Timeout: REG_RD_REQ with dir held 0.
  - Expect REG_RD_TMO exactly RD_TMO_CYC (16) cycles later. Read-pending then clears.
- Abort/reset: mid-packet dir falls -> RX_EOP=1 with RX_ERR=1.
  - Separately, assert RST mid-packet: all outputs reset at once, BUS_OWN=1, no EOP.
